// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: drives an SRAM-like req/addr_ok/data_ok bus and returns
// aligned, extended load data. Only one transaction is in flight; stallM covers it.
module mem_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memreadM,
    input  logic          memwriteM,
    input  logic [1:0]    sizeM,
    input  logic          signedM,
    input  logic [AW-1:0] aluoutM,
    input  logic [DW-1:0] writedataM,
    input  logic          flushM,
    input  logic          holdM,
    output logic [DW-1:0] readdataM,
    output logic          stallM,
    output logic          adelM,
    output logic          adesM,
    output logic [AW-1:0] badvaddrM,
    output logic          data_req,
    output logic          data_wr,
    output logic [3:0]    data_be,
    output logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_wdata,
    input  logic          data_addr_ok,
    input  logic [DW-1:0] data_rdata,
    input  logic          data_data_ok
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

    state_t        state_q, state_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] lat_addr_q;
    logic [1:0]    lat_off_q, lat_size_q;
    logic          lat_sgn_q, lat_wr_q;
    logic [3:0]    lat_be_q;
    logic [DW-1:0] lat_wdata_q;

    logic          misal, access, issue, latch_en;
    logic [3:0]    cur_be;
    logic [DW-1:0] cur_wdata, shifted, load_data;
    logic [AW-1:0] cur_addr;

    // size 2'b11 behaves as a word access
    assign misal     = (sizeM == 2'b01 && aluoutM[0]) || (sizeM[1] && aluoutM[1:0] != 2'b00);
    assign access    = memreadM | memwriteM;
    assign issue     = access & ~misal & ~flushM;
    assign adelM     = memreadM & misal & ~flushM;
    assign adesM     = memwriteM & misal & ~flushM;
    assign badvaddrM = aluoutM;
    assign cur_addr  = {aluoutM[AW-1:2], 2'b00};

    always_comb begin
        cur_be    = 4'b1111;
        cur_wdata = writedataM;
        if (memwriteM) begin
            case (sizeM)
                2'b00: begin
                    cur_be    = 4'b0001 << aluoutM[1:0];
                    cur_wdata = {4{writedataM[7:0]}};
                end
                2'b01: begin
                    cur_be    = aluoutM[1] ? 4'b1100 : 4'b0011;
                    cur_wdata = {2{writedataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign shifted = data_rdata >> {lat_off_q, 3'b000};

    always_comb begin
        case (lat_size_q)
            2'b00:   load_data = lat_sgn_q ? {{(DW-8){shifted[7]}}, shifted[7:0]}
                                           : {{(DW-8){1'b0}}, shifted[7:0]};
            2'b01:   load_data = lat_sgn_q ? {{(DW-16){shifted[15]}}, shifted[15:0]}
                                           : {{(DW-16){1'b0}}, shifted[15:0]};
            default: load_data = data_rdata;
        endcase
    end

    // Outside IDLE the bus sees only latched fields, so M-stage inputs may wander.
    assign data_wr    = (state_q == S_IDLE) ? memwriteM : lat_wr_q;
    assign data_be    = (state_q == S_IDLE) ? cur_be    : lat_be_q;
    assign data_addr  = (state_q == S_IDLE) ? cur_addr  : lat_addr_q;
    assign data_wdata = (state_q == S_IDLE) ? cur_wdata : lat_wdata_q;
    assign readdataM  = rdata_q;

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        rdata_d  = rdata_q;
        latch_en = 1'b0;
        data_req = 1'b0;
        stallM   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    data_req = 1'b1;
                    stallM   = 1'b1;
                    latch_en = 1'b1;
                    state_d  = data_addr_ok ? S_DATA : S_REQ;
                end
            end
            S_REQ: begin
                data_req = 1'b1;
                stallM   = 1'b1;
                if (flushM)       drop_d  = 1'b1;
                if (data_addr_ok) state_d = S_DATA;
            end
            S_DATA: begin
                stallM = 1'b1;
                if (flushM) drop_d = 1'b1;
                if (data_data_ok) begin
                    // a flush arriving with the response still discards it
                    if (drop_q || flushM) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        rdata_d = load_data;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (flushM || !holdM) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drop_q      <= 1'b0;
            rdata_q     <= '0;
            lat_addr_q  <= '0;
            lat_off_q   <= 2'b00;
            lat_size_q  <= 2'b00;
            lat_sgn_q   <= 1'b0;
            lat_wr_q    <= 1'b0;
            lat_be_q    <= 4'b0000;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            if (latch_en) begin
                lat_addr_q  <= cur_addr;
                lat_off_q   <= aluoutM[1:0];
                lat_size_q  <= sizeM;
                lat_sgn_q   <= signedM;
                lat_wr_q    <= memwriteM;
                lat_be_q    <= cur_be;
                lat_wdata_q <= cur_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios plus randomized accesses against an arithmetic model.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM, signedM, flushM, holdM;
    logic [1:0]  sizeM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM, badvaddrM;
    logic        stallM, adelM, adesM;
    logic        data_req, data_wr;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_load;

    mem_lsu #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .memreadM(memreadM), .memwriteM(memwriteM), .sizeM(sizeM), .signedM(signedM),
        .aluoutM(aluoutM), .writedataM(writedataM), .flushM(flushM), .holdM(holdM),
        .readdataM(readdataM), .stallM(stallM), .adelM(adelM), .adesM(adesM),
        .badvaddrM(badvaddrM), .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic on byte offsets.
    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sg,
                                           input logic [31:0] ad, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned off;
        off = ad % 4;
        v   = rd >> (8 * off);
        if (sz == 2'd0) begin
            v = v % 256;
            if (sg && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (sg && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input bit rd, input logic [1:0] sz, input logic [31:0] ad);
        int e;
        if (rd || sz[1]) return 4'hF;
        if (sz == 2'd0) e = 1 << (ad % 4);
        else            e = 3 << (ad % 4);
        return e[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd % 256) * 32'h01010101;
        if (sz == 2'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // Starts and ends at a negedge; M inputs are scrambled after issue to prove latching.
    task automatic do_access(input bit rd, input logic [1:0] sz, input bit sg,
                             input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rdat,
                             input int adly, input int ddly, input int hold, input string nm);
        logic [31:0] e_addr, e_wdata, e_rd;
        logic [3:0]  e_be;
        e_addr  = ad & ~32'h3;
        e_be    = m_be(rd, sz, ad);
        e_wdata = m_wdata(sz, wd);
        e_rd    = m_load(sz, sg, ad, rdat);
        memreadM = rd; memwriteM = !rd; sizeM = sz; signedM = sg;
        aluoutM = ad; writedataM = wd; flushM = 1'b0; holdM = 1'b0;
        for (int i = 0; i <= adly; i++) begin
            data_addr_ok = (i == adly);
            #1;
            n_tests++;
            if ({data_req, stallM} !== 2'b11) begin
                n_fail++; $display("FAIL %s req/stall c%0d: got %b want 11", nm, i, {data_req, stallM});
            end
            n_tests++;
            if (data_addr !== e_addr) begin
                n_fail++; $display("FAIL %s data_addr c%0d: got %h want %h", nm, i, data_addr, e_addr);
            end
            n_tests++;
            if (data_be !== e_be || data_wr !== !rd) begin
                n_fail++; $display("FAIL %s be/wr c%0d: got %b/%b want %b/%b", nm, i, data_be, data_wr, e_be, !rd);
            end
            if (!rd) begin
                n_tests++;
                if (data_wdata !== e_wdata) begin
                    n_fail++; $display("FAIL %s wdata c%0d: got %h want %h", nm, i, data_wdata, e_wdata);
                end
            end
            @(negedge clk);
            aluoutM = $urandom; writedataM = $urandom; sizeM = 2'($urandom); signedM = 1'($urandom);
        end
        data_addr_ok = 1'b0;
        for (int k = 1; k <= ddly; k++) begin
            data_data_ok = (k == ddly);
            data_rdata   = (k == ddly) ? rdat : $urandom;
            #1;
            n_tests++;
            if ({data_req, stallM} !== 2'b01) begin
                n_fail++; $display("FAIL %s wait req/stall d%0d: got %b want 01", nm, k, {data_req, stallM});
            end
            @(negedge clk);
        end
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
        for (int h = 0; h <= hold; h++) begin
            holdM = (h < hold);
            #1;
            n_tests++;
            if ({data_req, stallM} !== 2'b00) begin
                n_fail++; $display("FAIL %s done req/stall h%0d: got %b want 00", nm, h, {data_req, stallM});
            end
            if (rd) begin
                n_tests++;
                if (readdataM !== e_rd) begin
                    n_fail++; $display("FAIL %s readdata h%0d: got %h want %h", nm, h, readdataM, e_rd);
                end
            end
            @(negedge clk);
        end
        if (rd) last_load = e_rd;
        holdM = 1'b0; memreadM = 1'b0; memwriteM = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({data_req, stallM, adelM, adesM} !== 4'b0000 || readdataM !== 32'h0) begin
            n_fail++; $display("FAIL reset: got req/stall/adel/ades=%b rd=%h want 0000/0",
                               {data_req, stallM, adelM, adesM}, readdataM);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        do_access(1'b1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 0, "LB");
        #1;
        n_tests++;
        if (readdataM !== 32'hFFFFFF80) begin
            n_fail++; $display("FAIL LB const: got %h want FFFFFF80", readdataM);
        end
        @(negedge clk);
    endtask

    task automatic test_load_half();
        do_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0, 32'hBEEF0000, 0, 1, 0, "LHU");
        #1;
        n_tests++;
        if (readdataM !== 32'h0000BEEF) begin
            n_fail++; $display("FAIL LHU const: got %h want 0000BEEF", readdataM);
        end
        @(negedge clk);
        do_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0, 32'hBEEF0000, 3, 1, 0, "LHU_slow");
    endtask

    task automatic test_store();
        do_access(1'b0, 2'd0, 1'b0, 32'h3001, 32'h000000A5, 32'h0, 0, 1, 0, "SB");
        do_access(1'b0, 2'd1, 1'b0, 32'h3002, 32'h1234BEEF, 32'h0, 1, 2, 0, "SH");
    endtask

    task automatic test_misalign();
        logic [31:0] ad;
        bit rd, fl;
        logic [1:0] sz;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                rd = (i < 2); fl = i[0];
                sz = rd ? 2'd2 : 2'd1;
                ad = rd ? 32'h4002 : 32'h5001;
            end else begin
                rd = 1'($urandom); fl = 1'($urandom);
                sz = 2'($urandom_range(1, 3));
                ad = ($urandom & ~32'h3) | ((sz == 2'd1) ? 32'h1 : 32'($urandom_range(1, 3)));
            end
            memreadM = rd; memwriteM = !rd; sizeM = sz; aluoutM = ad; flushM = fl; signedM = 1'b0;
            #1;
            n_tests++;
            if (adelM !== (rd && !fl) || adesM !== (!rd && !fl)) begin
                n_fail++; $display("FAIL misalign flags %0d: got %b%b want %b%b", i, adelM, adesM,
                                   rd && !fl, !rd && !fl);
            end
            n_tests++;
            if ({data_req, stallM} !== 2'b00 || badvaddrM !== ad) begin
                n_fail++; $display("FAIL misalign req/stall/badv %0d: got %b %h want 00 %h", i,
                                   {data_req, stallM}, badvaddrM, ad);
            end
            @(negedge clk);
        end
        memreadM = 1'b0; memwriteM = 1'b0; flushM = 1'b0;
    endtask

    task automatic test_flush_data();
        do_access(1'b1, 2'd2, 1'b0, 32'h6100, 32'h0, 32'hCAFEF00D, 0, 1, 0, "LW_pre");
        memreadM = 1'b1; sizeM = 2'd2; signedM = 1'b0; aluoutM = 32'h6000; data_addr_ok = 1'b1;
        #1;
        n_tests++;
        if ({data_req, stallM} !== 2'b11) begin
            n_fail++; $display("FAIL flush issue: got %b want 11", {data_req, stallM});
        end
        @(negedge clk);
        data_addr_ok = 1'b0; flushM = 1'b1; memreadM = 1'b0;
        #1;
        n_tests++;
        if ({data_req, stallM} !== 2'b01) begin
            n_fail++; $display("FAIL flush in data: got %b want 01", {data_req, stallM});
        end
        @(negedge clk);
        flushM = 1'b0;
        #1;
        n_tests++;
        if ({data_req, stallM} !== 2'b01) begin
            n_fail++; $display("FAIL flush wait: got %b want 01", {data_req, stallM});
        end
        @(negedge clk);
        data_data_ok = 1'b1; data_rdata = 32'h12345678;
        #1;
        n_tests++;
        if (stallM !== 1'b1) begin
            n_fail++; $display("FAIL flush data_ok stall: got %b want 1", stallM);
        end
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        n_tests++;
        if (readdataM !== last_load || stallM !== 1'b0) begin
            n_fail++; $display("FAIL flush drop: got rd=%h stall=%b want %h 0", readdataM, stallM, last_load);
        end
        do_access(1'b1, 2'd0, 1'b0, 32'h7002, 32'h0, 32'h00AB0000, 0, 1, 0, "LBU_after_flush");
    endtask

    task automatic test_hold();
        do_access(1'b1, 2'd1, 1'b1, 32'h8000, 32'h0, 32'h1111F00F, 1, 1, 3, "LH_hold");
    endtask

    task automatic test_reset_in_data();
        memreadM = 1'b1; sizeM = 2'd2; signedM = 1'b0; aluoutM = 32'h9000; data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0; rst = 1'b1;
        #1;
        n_tests++;
        if (stallM !== 1'b1) begin
            n_fail++; $display("FAIL rst_data pre: stall got %b want 1", stallM);
        end
        @(negedge clk);
        rst = 1'b0; memreadM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        #1;
        n_tests++;
        if ({data_req, stallM} !== 2'b00 || readdataM !== 32'h0) begin
            n_fail++; $display("FAIL rst_data idle: got %b rd=%h want 00 0", {data_req, stallM}, readdataM);
        end
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        n_tests++;
        if (readdataM !== 32'h0 || stallM !== 1'b0) begin
            n_fail++; $display("FAIL rst_data stray: got rd=%h stall=%b want 0 0", readdataM, stallM);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] ad;
        bit rd;
        for (int i = 0; i < 30; i++) begin
            sz = 2'($urandom);
            rd = 1'($urandom);
            ad = $urandom & ~32'h3;
            if (sz == 2'd0)      ad = ad | 32'($urandom_range(0, 3));
            else if (sz == 2'd1) ad = ad | (32'($urandom_range(0, 1)) * 2);
            do_access(rd, sz, 1'($urandom), ad, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        rst = 1'b1; memreadM = 1'b0; memwriteM = 1'b0; sizeM = 2'd0; signedM = 1'b0;
        aluoutM = '0; writedataM = '0; flushM = 1'b0; holdM = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0; last_load = '0;
        @(negedge clk);
        test_reset();
        test_load_byte();
        test_load_half();
        test_store();
        test_misalign();
        test_flush_data();
        test_hold();
        test_reset_in_data();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Memory-stage load/store unit; sits directly downstream of the execute/memory pipeline register.
- Consumes the M-stage address (aluoutM), store data (writedataM) and access control, and drives an SRAM-like request/response data bus.
- Returns sign- or zero-extended load data as readdataM to the M/W register.
- Asserts stallM while a bus transaction is outstanding, and flags misaligned accesses as address-error exceptions.

Parameters:
- AW, 32, address width.
- DW, 32, data width (fixed at 32; byte-lane logic assumes 4 lanes).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- memreadM  in  1  load in M stage
- memwriteM  in  1  store in M stage
- sizeM  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- signedM  in  1  sign-extend load result
- aluoutM  in  32  effective address
- writedataM  in  32  store data, right-aligned
- flushM  in  1  kill the M-stage instruction (exception/branch)
- holdM  in  1  external stall keeping the same instruction in M
- readdataM  out  32  aligned/extended load data
- stallM  out  1  freeze pipeline while access pending
- adelM  out  1  load address error
- adesM  out  1  store address error
- badvaddrM  out  32  faulting address
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_be  out  4  byte enables
- data_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  response valid

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. readdataM=0. Drop flag and latched access info cleared. Combinational outputs follow from the IDLE state with no access.
- Any transaction outstanding at reset is abandoned; data_data_ok is ignored in every state except DATA.
- Misalignment (combinational):
  - half with addr[0]=1, or word with addr[1:0]!=0.
  - Load sets adelM; store sets adesM; badvaddrM=aluoutM in the same cycle.
  - No request is issued and stallM=0.
  - adelM/adesM are masked by flushM.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{wd[15:0]}}.
  - SW: be=4'b1111, wdata=wd.
  - Loads drive be=4'b1111.
- Access info (addr[1:0], size, signed, wr, be, wdata) is latched on the cycle the request first issues. It is held stable in REQ regardless of M-stage inputs.
- FSM:
  - IDLE:
    - Issue condition: valid access = (memreadM|memwriteM) & ~misaligned & ~flushM.
    - On issue: data_req=1 this cycle, stallM=1. addr_ok → DATA; otherwise → REQ.
    - No valid access: data_req=0, stallM=0.
  - REQ: data_req=1 with latched fields, stallM=1; addr_ok → DATA. flushM here sets the drop flag; the request is never withdrawn.
  - DATA: data_req=0, stallM=1.
    - flushM sets the drop flag.
    - On data_data_ok with drop clear: load readdataM register with aligned data, → DONE.
    - On data_data_ok with drop set: → IDLE, clear drop, readdataM unchanged.
  - DONE: stallM=0, readdataM valid. If holdM=1, stay in DONE with no re-issue and the result held. If holdM=0, → IDLE. flushM in DONE: → IDLE.
- Load alignment: shifted = data_rdata >> (8*addr[1:0]).
  - byte: signed ? sext(shifted[7:0]) : zext.
  - half: signed ? sext(shifted[15:0]) : zext.
  - word: data_rdata.
  - Store completion also passes through DONE; readdataM is undefined-but-stable for stores (it is loaded with the bus value).
- Latency with zero-wait bus (addr_ok in issue cycle, data_ok next cycle): 2 stall cycles, result visible in the third cycle.
- Only one outstanding transaction. No new request is issued until the FSM has returned to IDLE.

Test Plan:
- LB signed, addr=0x1003, rdata=0x80FF1234, addr_ok immediate, data_ok +1 → req 1 cycle, be=1111, data_addr=0x1000, stallM high 2 cycles, DONE readdataM=0xFFFFFF80.
- LHU addr=0x2002, rdata=0xBEEF0000 → readdataM=0x0000BEEF. Same with addr_ok delayed 3 cycles → data_req held 4 cycles with constant addr, stallM high 5 cycles.
- SB addr=0x3001, wd=0x000000A5 → data_wr=1, be=0010, wdata=0xA5A5A5A5. SH addr=0x3002 → be=1100.
- LW addr=0x4002 → adelM=1, badvaddrM=0x4002, data_req=0, stallM=0. SH addr=0x5001 → adesM=1. Either with flushM=1 → no flags.
- flushM during DATA, data_ok 2 cycles later → stallM held until data_ok, FSM → IDLE directly, readdataM unchanged, next request issues the following cycle.
- holdM=1 for 3 cycles in DONE → no extra data_req, readdataM constant. rst asserted in DATA → IDLE next cycle, readdataM=0, subsequent stray data_ok ignored.
